// File: rtl/loop_buffer_block_reader.sv
// Read-side drain engine for the asynchronous loop buffer (read clock domain).
// Waits for a committed block, issues its in-block read addresses, captures
// the returning RAM data into a small skid FIFO and streams the words out
// with SOP/EOP markers and the block info. The buffer slot is released when
// all of the block's read data has been captured locally.

// Sanity checks on internal occupancy; never part of the datapath.
module loop_buffer_block_reader_chk (
    input logic clk_i,
    input logic rst_i,
    input logic fifo_wr_i,
    input logic fifo_full_i,
    input logic iq_push_i,
    input logic iq_full_i
);
    a_skid_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
        !(fifo_wr_i && fifo_full_i));
    a_info_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
        !(iq_push_i && iq_full_i));
endmodule

module loop_buffer_block_reader #(
    parameter int RADDR_WIDTH    = 8,
    parameter int RDATA_WIDTH    = 64,
    parameter int INFO_WIDTH     = 256,
    parameter int READ_LATENCY   = 3,
    parameter int OUT_FIFO_DEPTH = 8
) (
    input  logic                   rd_clk,
    input  logic                   rd_rst,
    input  logic                   buf_rd_vld,
    input  logic [INFO_WIDTH-1:0]  buf_rd_info,
    output logic                   buf_rd_rdy,
    output logic [RADDR_WIDTH-1:0] buf_rd_addr,
    input  logic [RDATA_WIDTH-1:0] buf_rd_data,
    output logic [RDATA_WIDTH-1:0] m_data,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic                   m_sop,
    output logic                   m_eop,
    output logic [INFO_WIDTH-1:0]  m_info,
    output logic                   busy,
    output logic [31:0]            blk_cnt
);
    localparam int LEN_W = RADDR_WIDTH + 1;
    localparam int PTR_W = $clog2(OUT_FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int CRD_W = 16;
    localparam logic [LEN_W-1:0] MAX_LEN = {1'b1, {RADDR_WIDTH{1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_ISSUE   = 3'd2,
        S_WAIT    = 3'd3,
        S_RELEASE = 3'd4,
        S_GAP     = 3'd5
    } state_t;

    state_t                   state_q;
    logic [LEN_W-1:0]         len_q;
    logic [LEN_W-1:0]         len_d;
    logic [LEN_W-1:0]         cnt_q;
    logic [RADDR_WIDTH-1:0]   addr_q;
    logic                     iss_vld_q;
    logic                     iss_sop_q;
    logic                     iss_eop_q;
    logic                     rdy_q;
    logic [31:0]              blk_cnt_q;

    logic [READ_LATENCY-1:0]  pipe_vld_q;
    logic [READ_LATENCY-1:0]  pipe_sop_q;
    logic [READ_LATENCY-1:0]  pipe_eop_q;
    logic [CRD_W-1:0]         inflight_s;
    logic [CRD_W-1:0]         remain_s;
    logic [CRD_W-1:0]         credit_used_s;
    logic                     credit_s;

    logic [RDATA_WIDTH+1:0]   fifo_mem_q [OUT_FIFO_DEPTH];
    logic [CNT_W-1:0]         fifo_wr_q;
    logic [CNT_W-1:0]         fifo_rd_q;
    logic [CNT_W-1:0]         fifo_cnt_s;
    logic                     fifo_wr_s;
    logic                     fifo_rd_s;
    logic                     fifo_empty_s;
    logic                     fifo_full_s;
    logic [RDATA_WIDTH+1:0]   fifo_head_s;

    logic [INFO_WIDTH-1:0]    iq_mem_q [2];
    logic                     iq_wr_q;
    logic                     iq_rd_q;
    logic [1:0]               iq_cnt_q;
    logic                     iq_push_s;
    logic                     iq_pop_s;
    logic                     iq_full_s;

    assign fifo_cnt_s   = fifo_wr_q - fifo_rd_q;
    assign fifo_empty_s = (fifo_cnt_s == {CNT_W{1'b0}});
    assign fifo_full_s  = (fifo_cnt_s == CNT_W'(OUT_FIFO_DEPTH));
    assign fifo_wr_s    = pipe_vld_q[READ_LATENCY-1];
    assign fifo_rd_s    = m_valid && m_ready;
    assign fifo_head_s  = fifo_mem_q[fifo_rd_q[PTR_W-1:0]];

    assign iq_full_s    = (iq_cnt_q == 2'd2);
    assign iq_push_s    = (state_q == S_LOAD) && (len_d != {LEN_W{1'b0}});
    assign iq_pop_s     = fifo_rd_s && m_eop;

    assign buf_rd_rdy   = rdy_q;
    assign buf_rd_addr  = addr_q;
    assign blk_cnt      = blk_cnt_q;
    assign busy         = (state_q != S_IDLE) || !fifo_empty_s;
    assign m_valid      = !fifo_empty_s;
    assign m_data       = fifo_empty_s ? {RDATA_WIDTH{1'b0}} : fifo_head_s[RDATA_WIDTH+1:2];
    assign m_sop        = !fifo_empty_s && fifo_head_s[1];
    assign m_eop        = !fifo_empty_s && fifo_head_s[0];
    assign m_info       = (iq_cnt_q == 2'd0) ? {INFO_WIDTH{1'b0}} : iq_mem_q[iq_rd_q];

    // Block length from the info head, clamped to the largest legal block.
    always_comb begin
        len_d = buf_rd_info[RADDR_WIDTH:0];
        if (buf_rd_info[RADDR_WIDTH:0] > MAX_LEN) begin
            len_d = MAX_LEN;
        end else begin
            len_d = buf_rd_info[RADDR_WIDTH:0];
        end
    end

    // In-flight reads and issue credit (in-flight + skid occupancy must fit the skid FIFO).
    always_comb begin
        inflight_s = CRD_W'(iss_vld_q);
        for (int i = 0; i < READ_LATENCY; i++) begin
            inflight_s = inflight_s + CRD_W'(pipe_vld_q[i]);
        end
        // reads still outstanding once the oldest one is captured this cycle
        remain_s      = inflight_s - CRD_W'(pipe_vld_q[READ_LATENCY-1]);
        credit_used_s = inflight_s + CRD_W'(fifo_cnt_s);
        credit_s      = (credit_used_s < CRD_W'(OUT_FIFO_DEPTH));
    end

    // Block sequencing FSM with registered address, tag, release and counter outputs.
    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            state_q   <= S_IDLE;
            len_q     <= {LEN_W{1'b0}};
            cnt_q     <= {LEN_W{1'b0}};
            addr_q    <= {RADDR_WIDTH{1'b0}};
            iss_vld_q <= 1'b0;
            iss_sop_q <= 1'b0;
            iss_eop_q <= 1'b0;
            rdy_q     <= 1'b0;
            blk_cnt_q <= 32'd0;
        end else begin
            iss_vld_q <= 1'b0;
            rdy_q     <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (buf_rd_vld && !iq_full_s) begin
                        state_q <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    len_q <= len_d;
                    cnt_q <= {LEN_W{1'b0}};
                    if (len_d == {LEN_W{1'b0}}) begin
                        state_q   <= S_RELEASE;
                        rdy_q     <= 1'b1;
                        blk_cnt_q <= blk_cnt_q + 32'd1;
                    end else begin
                        state_q <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (credit_s) begin
                        addr_q    <= cnt_q[RADDR_WIDTH-1:0];
                        iss_vld_q <= 1'b1;
                        iss_sop_q <= (cnt_q == {LEN_W{1'b0}});
                        iss_eop_q <= (cnt_q == len_q - LEN_W'(1));
                        cnt_q     <= cnt_q + LEN_W'(1);
                        if (cnt_q == len_q - LEN_W'(1)) begin
                            state_q <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    // the last word lands in the skid FIFO at this edge
                    if (remain_s == {CRD_W{1'b0}}) begin
                        state_q   <= S_RELEASE;
                        rdy_q     <= 1'b1;
                        blk_cnt_q <= blk_cnt_q + 32'd1;
                    end
                end
                S_RELEASE: begin
                    state_q <= S_GAP;
                end
                S_GAP: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Tag shift register aligning sop/eop with the RAM read latency.
    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            pipe_vld_q <= {READ_LATENCY{1'b0}};
            pipe_sop_q <= {READ_LATENCY{1'b0}};
            pipe_eop_q <= {READ_LATENCY{1'b0}};
        end else begin
            pipe_vld_q[0] <= iss_vld_q;
            pipe_sop_q[0] <= iss_sop_q;
            pipe_eop_q[0] <= iss_eop_q;
            for (int i = 1; i < READ_LATENCY; i++) begin
                pipe_vld_q[i] <= pipe_vld_q[i-1];
                pipe_sop_q[i] <= pipe_sop_q[i-1];
                pipe_eop_q[i] <= pipe_eop_q[i-1];
            end
        end
    end

    // Skid FIFO storage: capture {data, sop, eop} as the tag exits the pipeline.
    always_ff @(posedge rd_clk) begin
        if (fifo_wr_s) begin
            fifo_mem_q[fifo_wr_q[PTR_W-1:0]] <= {buf_rd_data,
                                                 pipe_sop_q[READ_LATENCY-1],
                                                 pipe_eop_q[READ_LATENCY-1]};
        end
    end

    // Skid FIFO pointers.
    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            fifo_wr_q <= {CNT_W{1'b0}};
            fifo_rd_q <= {CNT_W{1'b0}};
        end else begin
            if (fifo_wr_s) begin
                fifo_wr_q <= fifo_wr_q + CNT_W'(1);
            end
            if (fifo_rd_s) begin
                fifo_rd_q <= fifo_rd_q + CNT_W'(1);
            end
        end
    end

    // Two-entry info queue: pushed on LOAD, popped when a block's EOP leaves.
    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            iq_mem_q[0] <= {INFO_WIDTH{1'b0}};
            iq_mem_q[1] <= {INFO_WIDTH{1'b0}};
            iq_wr_q     <= 1'b0;
            iq_rd_q     <= 1'b0;
            iq_cnt_q    <= 2'd0;
        end else begin
            if (iq_push_s) begin
                iq_mem_q[iq_wr_q] <= buf_rd_info;
                iq_wr_q           <= ~iq_wr_q;
            end
            if (iq_pop_s) begin
                iq_rd_q <= ~iq_rd_q;
            end
            case ({iq_push_s, iq_pop_s})
                2'b10:   iq_cnt_q <= iq_cnt_q + 2'd1;
                2'b01:   iq_cnt_q <= iq_cnt_q - 2'd1;
                default: iq_cnt_q <= iq_cnt_q;
            endcase
        end
    end

    loop_buffer_block_reader_chk u_chk (
        .clk_i       (rd_clk),
        .rst_i       (rd_rst),
        .fifo_wr_i   (fifo_wr_s),
        .fifo_full_i (fifo_full_s),
        .iq_push_i   (iq_push_s),
        .iq_full_i   (iq_full_s)
    );

endmodule

// File: tb/tb_loop_buffer_block_reader.sv
// Bench for loop_buffer_block_reader: a behavioural loop buffer (queue of
// committed blocks plus a fixed-latency RAM) feeds the reader; the expected
// output stream is the concatenation of every committed block's words.
module tb_loop_buffer_block_reader;
    localparam int RL = 3;

    typedef struct {
        logic [255:0] info;
        logic [63:0]  salt;
        int           uid;
    } blk_t;

    typedef struct {
        logic [63:0]  data;
        logic         sop;
        logic         eop;
        logic [255:0] info;
    } beat_t;

    logic         rd_clk = 1'b0;
    logic         rd_rst;
    logic         buf_rd_vld;
    logic [255:0] buf_rd_info;
    logic         buf_rd_rdy;
    logic [7:0]   buf_rd_addr;
    logic [63:0]  buf_rd_data;
    logic [63:0]  m_data;
    logic         m_valid;
    logic         m_ready;
    logic         m_sop;
    logic         m_eop;
    logic [255:0] m_info;
    logic         busy;
    logic [31:0]  blk_cnt;

    int    total = 0;
    int    bad = 0;
    int    cyc = 0;
    int    next_uid = 1;
    int    committed = 0;
    int    released = 0;
    int    rdy_mode = 0;
    int    rdy_cyc = -1;
    int    addr1_cyc = -1;
    int    addr3_cyc = -1;
    logic [7:0] prev_addr = 8'd0;
    logic [7:0] hist [0:RL];
    blk_t  bufq [$];
    beat_t expq [$];

    loop_buffer_block_reader dut (
        .rd_clk      (rd_clk),
        .rd_rst      (rd_rst),
        .buf_rd_vld  (buf_rd_vld),
        .buf_rd_info (buf_rd_info),
        .buf_rd_rdy  (buf_rd_rdy),
        .buf_rd_addr (buf_rd_addr),
        .buf_rd_data (buf_rd_data),
        .m_data      (m_data),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_sop       (m_sop),
        .m_eop       (m_eop),
        .m_info      (m_info),
        .busy        (busy),
        .blk_cnt     (blk_cnt)
    );

    always #5 rd_clk = ~rd_clk;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] ram_word(input blk_t b, input int a);
        return b.salt ^ {32'(b.uid), 32'(a)};
    endfunction

    // Commit a block to the buffer and append its expected output words.
    task automatic commit(input int len_field);
        blk_t b;
        int   eff;
        logic [31:0] lf;
        lf     = 32'(len_field);
        b.uid  = next_uid;
        next_uid++;
        b.salt = {$urandom, $urandom};
        for (int w = 0; w < 8; w++) b.info[w*32 +: 32] = $urandom;
        b.info[8:0] = lf[8:0];
        eff = (len_field > 256) ? 256 : len_field;
        bufq.push_back(b);
        for (int i = 0; i < eff; i++) begin
            beat_t e;
            e.data = ram_word(b, i);
            e.sop  = (i == 0);
            e.eop  = (i == eff - 1);
            e.info = b.info;
            expq.push_back(e);
        end
        committed++;
    endtask

    // One clock: check the beat about to transfer, track releases, drive buffer and RAM.
    task automatic step();
        @(negedge rd_clk);
        cyc++;
        case (rdy_mode)
            0: m_ready = 1'b1;
            1: m_ready = 1'b0;
            2: m_ready = 1'($urandom_range(0, 1));
            3: m_ready = ~m_ready;
            default: m_ready = 1'b1;
        endcase
        if (m_valid && m_ready) begin
            chk("beat_avail", 256'(expq.size() != 0), 256'(1));
            if (expq.size() != 0) begin
                beat_t e;
                e = expq.pop_front();
                chk("beat_data", 256'(m_data), 256'(e.data));
                chk("beat_sop",  256'(m_sop),  256'(e.sop));
                chk("beat_eop",  256'(m_eop),  256'(e.eop));
                chk("beat_info", m_info, e.info);
            end
        end
        if (buf_rd_rdy) begin
            released++;
            rdy_cyc = cyc;
            chk("blk_cnt_at_release", 256'(blk_cnt), 256'(released));
            chk("release_has_block", 256'(bufq.size() != 0), 256'(1));
            if (bufq.size() != 0) void'(bufq.pop_front());
        end
        if (buf_rd_addr != prev_addr) begin
            if (buf_rd_addr == 8'd1) addr1_cyc = cyc;
            if (buf_rd_addr == 8'd3) addr3_cyc = cyc;
            prev_addr = buf_rd_addr;
        end
        buf_rd_vld  = (bufq.size() != 0);
        buf_rd_info = (bufq.size() != 0) ? bufq[0].info : 256'd0;
        for (int i = RL; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = buf_rd_addr;
        buf_rd_data = (bufq.size() != 0) ? ram_word(bufq[0], int'(hist[RL])) : 64'd0;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((bufq.size() != 0 || expq.size() != 0 || busy) && n < budget) begin
            step();
            n++;
        end
        chk("drain_left", 256'(bufq.size() + expq.size() + int'(busy)), 256'(0));
    endtask

    task automatic check_reset_outputs(input string pfx);
        chk({pfx, "_rdy"},   256'(buf_rd_rdy),  256'(0));
        chk({pfx, "_addr"},  256'(buf_rd_addr), 256'(0));
        chk({pfx, "_valid"}, 256'(m_valid),     256'(0));
        chk({pfx, "_sop"},   256'(m_sop),       256'(0));
        chk({pfx, "_eop"},   256'(m_eop),       256'(0));
        chk({pfx, "_data"},  256'(m_data),      256'(0));
        chk({pfx, "_info"},  m_info,            256'(0));
        chk({pfx, "_busy"},  256'(busy),        256'(0));
        chk({pfx, "_blk"},   256'(blk_cnt),     256'(0));
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        rd_rst      = 1'b1;
        buf_rd_vld  = 1'b0;
        buf_rd_info = 256'd0;
        buf_rd_data = 64'd0;
        m_ready     = 1'b0;
        for (int i = 0; i <= RL; i++) hist[i] = 8'd0;
        repeat (3) step();
        check_reset_outputs("reset");
        rd_rst = 1'b0;
        step();

        // len=4, always ready: consecutive addresses, release 4 cycles after addr 3
        rdy_mode = 0;
        commit(4);
        drain(200);
        chk("len4_addr_rate", 256'(addr3_cyc - addr1_cyc), 256'(2));
        chk("len4_rdy_lat", 256'(rdy_cyc - addr3_cyc), 256'(4));
        chk("len4_blk_cnt", 256'(blk_cnt), 256'(1));

        // zero-length block: release only, no beats
        commit(0);
        drain(100);
        chk("len0_blk_cnt", 256'(blk_cnt), 256'(2));
        chk("len0_addr_idle", 256'(buf_rd_addr), 256'(3));

        // len=20 with no downstream ready: issue stops after the skid FIFO depth
        rdy_mode = 1;
        commit(20);
        repeat (40) step();
        chk("stall_addr", 256'(buf_rd_addr), 256'(7));
        chk("stall_valid", 256'(m_valid), 256'(1));
        chk("stall_no_release", 256'(blk_cnt), 256'(2));
        rdy_mode = 0;
        drain(300);
        chk("len20_blk_cnt", 256'(blk_cnt), 256'(3));

        // three back-to-back len=2 blocks with toggling ready
        rdy_mode = 3;
        commit(2);
        commit(2);
        commit(2);
        drain(300);
        chk("b2b_blk_cnt", 256'(blk_cnt), 256'(6));

        // maximum length and a clamped over-long length field
        rdy_mode = 2;
        commit(256);
        commit(300);
        drain(4000);
        chk("maxlen_blk_cnt", 256'(blk_cnt), 256'(8));

        // reset in the middle of issuing a len=16 block
        rdy_mode = 0;
        commit(16);
        begin
            int n = 0;
            while (buf_rd_addr != 8'd5 && n < 100) begin
                step();
                n++;
            end
        end
        chk("mid_issue_reached", 256'(buf_rd_addr), 256'(5));
        rd_rst = 1'b1;
        #1;
        check_reset_outputs("midrst");
        bufq.delete();
        expq.delete();
        released  = 0;
        committed = 0;
        prev_addr = 8'd0;
        for (int i = 0; i <= RL; i++) hist[i] = 8'd0;
        repeat (3) step();
        chk("midrst_no_release", 256'(released), 256'(0));
        rd_rst = 1'b0;
        commit(5);
        drain(200);
        chk("post_rst_blk_cnt", 256'(blk_cnt), 256'(1));

        // randomized traffic: random lengths, gaps and downstream ready
        rdy_mode = 2;
        for (int k = 0; k < 30; k++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r == 0)      commit(0);
            else if (r == 1) commit(256 + $urandom_range(0, 255));
            else             commit($urandom_range(1, 40));
            repeat ($urandom_range(0, 15)) step();
        end
        drain(30000);
        chk("final_blk_cnt", 256'(blk_cnt), 256'(committed));
        chk("final_busy", 256'(busy), 256'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
